aes_gf16_mul_serial: RTL and testbench



---
 rtl/aes_gf16_mul_serial.sv | 127 ++++++++++++
 tb/tb_aes_gf16_mul_serial.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_gf16_mul_serial.sv
// Bit-serial GF(2^4) multiplier (field polynomial x^4 + MOD_POLY), MSB-first
// shift-and-add over 4 cycles, valid/ready on both sides.
// Optional macro AES_GF16_MUL_BACK2BACK_EN: accept the next operand pair in the
// same DONE cycle the product is taken, skipping IDLE.
module aes_gf16_mul_serial #(
  localparam int unsigned NW = 4,
  parameter logic [NW-1:0] MOD_POLY = 4'b0011
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [NW-1:0] operand_a_i,
  input  logic [NW-1:0] operand_b_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [NW-1:0] product_o,
  output logic          busy_o
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   a_q, b_q, acc_q;
  logic [CW-1:0]   cnt_q;
  logic [NW-1:0]   acc_step;
  logic            in_hs;

  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic [NW-1:0]   product_q, product_d;

  // Multiply by x modulo the field polynomial
  function automatic logic [NW-1:0] xt(input logic [NW-1:0] v);
    return {v[NW-2:0], 1'b0} ^ (v[NW-1] ? MOD_POLY : NW'(0));
  endfunction

  // One Horner step: shift accumulator, add multiplicand when the b bit is set
  assign acc_step = xt(acc_q) ^ (b_q[cnt_q] ? a_q : NW'(0));

`ifdef AES_GF16_MUL_BACK2BACK_EN
  // Ready also in DONE while downstream takes the product
  assign in_ready_o = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
`else
  logic ready_q, ready_d;
  assign in_ready_o = ready_q;
`endif

  assign in_hs       = in_valid_i && in_ready_o;
  assign out_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign product_o   = product_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = BUSY;
      BUSY:    if (cnt_q == CW'(0)) state_d = DONE;
      DONE:    if (out_ready_i) state_d = in_hs ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the next state
  always_comb begin
    valid_d   = (state_d == DONE);
    busy_d    = (state_d == BUSY);
    product_d = NW'(0);
    if (state_d == DONE) begin
      product_d = (state_q == BUSY) ? acc_step : product_q;
    end
`ifndef AES_GF16_MUL_BACK2BACK_EN
    ready_d = (state_d == IDLE);
`endif
  end

  // Output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      product_q <= NW'(0);
`ifndef AES_GF16_MUL_BACK2BACK_EN
      ready_q   <= 1'b1;
`endif
    end else begin
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      product_q <= product_d;
`ifndef AES_GF16_MUL_BACK2BACK_EN
      ready_q   <= ready_d;
`endif
    end
  end

  // Operand capture and serial accumulate
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= NW'(0);
      b_q   <= NW'(0);
      acc_q <= NW'(0);
      cnt_q <= CW'(0);
    end else if (in_hs) begin
      a_q   <= operand_a_i;
      b_q   <= operand_b_i;
      acc_q <= NW'(0);
      cnt_q <= CW'(3);
    end else if (state_q == BUSY) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_aes_gf16_mul_serial.sv
// Directed bench for aes_gf16_mul_serial; honours AES_GF16_MUL_BACK2BACK_EN.
module tb_aes_gf16_mul_serial;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [3:0] operand_a_i = 4'h0;
  logic [3:0] operand_b_i = 4'h0;
  logic       out_valid_o;
  logic       out_ready_i = 1'b1;
  logic [3:0] product_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  aes_gf16_mul_serial dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .product_o   (product_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: LSB-first polynomial multiply reduced by x^4 + x + 1
  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'({4'h0, a}) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One full operation with cycle-accurate checks of the 4 BUSY cycles and DONE
  task automatic test_product(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] exp, input string name);
    int busy_cnt;
    int waited;
    out_ready_i = 1'b1;
    waited = 0;
    while (!in_ready_o && waited < 20) begin
      step();
      waited++;
    end
    total++;
    if (in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_wait: in_ready_o=%b want 1", name, in_ready_o);
    end
    in_valid_i  = 1'b1;
    operand_a_i = a;
    operand_b_i = b;
    step();
    in_valid_i  = 1'b0;
    operand_a_i = ~a;
    operand_b_i = ~b;
    busy_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      if (busy_o === 1'b1) busy_cnt++;
      total++;
      if (out_valid_o !== 1'b0 || product_o !== 4'h0 || in_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL %s busy_cyc%0d: valid=%b prod=%h rdy=%b want 0/0/0",
                 name, c, out_valid_o, product_o, in_ready_o);
      end
      step();
    end
    total++;
    if (out_valid_o !== 1'b1 || product_o !== exp || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s done: valid=%b prod=%h busy=%b want 1/%h/0",
               name, out_valid_o, product_o, busy_o, exp);
    end
    total++;
    if (busy_cnt != 4) begin
      bad++;
      $display("FAIL %s busy_len: got %0d want 4", name, busy_cnt);
    end
    step();
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || product_o !== 4'h0) begin
      bad++;
      $display("FAIL %s after: valid=%b rdy=%b prod=%h want 0/1/0",
               name, out_valid_o, in_ready_o, product_o);
    end
  endtask

  task automatic test_reset();
    logic saw_valid;
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || product_o !== 4'h0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b valid=%b prod=%h busy=%b want 1/0/0/0",
               in_ready_o, out_valid_o, product_o, busy_o);
    end
    // Reset mid-BUSY: accept in cycle 0, reset asserted in cycle 2
    in_valid_i = 1'b1; operand_a_i = 4'h7; operand_b_i = 4'h3;
    step();
    in_valid_i = 1'b0;
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy_entry: busy=%b want 1", busy_o);
    end
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || product_o !== 4'h0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_busy: rdy=%b valid=%b prod=%h busy=%b want 1/0/0/0",
               in_ready_o, out_valid_o, product_o, busy_o);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0) saw_valid = 1'b1;
      step();
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_discard: activity=%b want 0", saw_valid);
    end
    // Reset while holding a product in DONE
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; operand_a_i = 4'h2; operand_b_i = 4'h8;
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (out_valid_o !== 1'b1 || product_o !== 4'h3) begin
      bad++;
      $display("FAIL reset_pre_done: valid=%b prod=%h want 1/3", out_valid_o, product_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    total++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || product_o !== 4'h0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_done: rdy=%b valid=%b prod=%h busy=%b want 1/0/0/0",
               in_ready_o, out_valid_o, product_o, busy_o);
    end
  endtask

  task automatic test_reduction();
    test_product(4'h2, 4'h8, 4'h3, "red_2x8");
    test_product(4'hF, 4'hF, 4'hA, "red_FxF");
  endtask

  task automatic test_general();
    test_product(4'h3, 4'h7, 4'h9, "gen_3x7");
    test_product(4'h7, 4'h3, 4'h9, "gen_7x3");
    test_product(4'h1, 4'hB, 4'hB, "gen_1xB");
    test_product(4'h0, 4'hE, 4'h0, "gen_0xE");
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; operand_a_i = 4'h3; operand_b_i = 4'h7;
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid_o !== 1'b1 || product_o !== 4'h9 || in_ready_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%b prod=%h rdy=%b busy=%b want 1/9/0/0",
                 i, out_valid_o, product_o, in_ready_o, busy_o);
      end
      operand_a_i = 4'(i);
      in_valid_i  = ~in_valid_i;
      step();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    total++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || product_o !== 4'h0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: valid=%b rdy=%b prod=%h busy=%b want 0/1/0/0",
               out_valid_o, in_ready_o, product_o, busy_o);
    end
    step();
    total++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_no_capture: busy=%b valid=%b want 0/0", busy_o, out_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int idx, nd, t0, t1, exp_t1;
    logic [3:0] p0, p1;
    logic hs;
`ifdef AES_GF16_MUL_BACK2BACK_EN
    exp_t1 = 10;
`else
    exp_t1 = 11;
`endif
    idx = 0; nd = 0; t0 = -1; t1 = -1; p0 = 4'h0; p1 = 4'h0;
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; operand_a_i = 4'h2; operand_b_i = 4'h8;
    for (int cyc = 0; cyc < 20; cyc++) begin
      hs = in_valid_i && in_ready_o;
      step();
      if (hs) begin
        idx++;
        if (idx == 1) begin
          operand_a_i = 4'h3; operand_b_i = 4'h7;
        end else begin
          in_valid_i = 1'b0;
        end
      end
      if (out_valid_o === 1'b1) begin
        if (nd == 0) begin t0 = cyc + 1; p0 = product_o; end
        else if (nd == 1) begin t1 = cyc + 1; p1 = product_o; end
        nd++;
      end
    end
    in_valid_i = 1'b0;
    total++;
    if (nd != 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d products want 2", nd);
    end
    total++;
    if (t0 != 5 || p0 !== 4'h3) begin
      bad++;
      $display("FAIL b2b_first: cycle=%0d prod=%h want 5/3", t0, p0);
    end
    total++;
    if (t1 != exp_t1 || p1 !== 4'h9) begin
      bad++;
      $display("FAIL b2b_second: cycle=%0d prod=%h want %0d/9", t1, p1, exp_t1);
    end
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        test_product(4'(a), 4'(b), ref_mul(4'(a), 4'(b)), $sformatf("exh_%0h_%0h", a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_reduction();
    test_general();
    test_backpressure();
    test_back_to_back();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
